// File: rtl/mst_rx_fifo_reader.sv
// Master-side receive engine for a synchronous 245-style FIFO bus.
// Drives oe_n/rd_n from rxf_n and buffers bytes into a 2-deep valid/ready stream.
module mst_rx_fifo_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxf_n_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              oe_n_o,
  output logic              rd_n_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [CNT_W-1:0]  empty_counter_o,
  output logic [CNT_W-1:0]  words_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] TURN = 2'd1;
  localparam logic [1:0] READ = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              oe_nx;
  logic              rd_nx;

  logic [1:0]        occ;
  logic [1:0]        occ_nx;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic              capture;
  logic              pop;
  logic              room;
  logic              tail_wr;
  logic              restart;

  assign capture   = !rd_n_o && !rxf_n_i;
  assign pop       = m_valid_o && m_ready_i;
  assign m_valid_o = (occ != 2'd0);
  assign m_data_o  = head;

  always_comb begin
    occ_nx = occ + {1'b0, capture} - {1'b0, pop};
  end

  // Room for one more byte after this edge is what permits a strobe.
  assign room = (occ_nx <= 2'd1);

  // Tail is written when the new byte lands behind a surviving head.
  assign tail_wr = capture &&
                   ((occ == 2'd1 && !pop) ||
                    (occ == 2'd2 && pop));

  always_comb begin
    state_nx = state;
    oe_nx    = oe_n_o;
    rd_nx    = rd_n_o;
    unique case (state)
      IDLE: begin
        oe_nx = 1'b1;
        rd_nx = 1'b1;
        if (!rxf_n_i && room) begin
          state_nx = TURN;
          oe_nx    = 1'b0;
        end
      end
      TURN: begin
        if (rxf_n_i) begin
          state_nx = IDLE;
          oe_nx    = 1'b1;
          rd_nx    = 1'b1;
        end else begin
          state_nx = READ;
          oe_nx    = 1'b0;
          rd_nx    = !room;
        end
      end
      READ: begin
        if (rxf_n_i) begin
          state_nx = IDLE;
          oe_nx    = 1'b1;
          rd_nx    = 1'b1;
        end else begin
          oe_nx = 1'b0;
          rd_nx = !room;
        end
      end
      default: begin
        state_nx = IDLE;
        oe_nx    = 1'b1;
        rd_nx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      oe_n_o <= 1'b1;
      rd_n_o <= 1'b1;
    end else begin
      state  <= state_nx;
      oe_n_o <= oe_nx;
      rd_n_o <= rd_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      occ <= occ_nx;
      if (pop) begin
        if (capture && occ == 2'd1) begin
          head <= data_i;
        end else begin
          head <= tail;
        end
      end else if (capture && occ == 2'd0) begin
        head <= data_i;
      end
      if (tail_wr) begin
        tail <= data_i;
      end
    end
  end

  // A run restarts at 1 once any non-empty cycle has been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      empty_counter_o <= '0;
      restart         <= 1'b0;
    end else if (rxf_n_i) begin
      restart <= 1'b0;
      if (restart) begin
        empty_counter_o <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (empty_counter_o != CNT_MAX) begin
        empty_counter_o <= empty_counter_o + 1'b1;
      end
    end else begin
      restart <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_o <= '0;
    end else if (capture && words_o != CNT_MAX) begin
      words_o <= words_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_mst_rx_fifo_reader.sv
// Bench for mst_rx_fifo_reader: hand vectors, directed bursts and a
// randomized run against a queue-based reference model.
module tb_mst_rx_fifo_reader;

  logic       clk;
  logic       rst;
  logic       rxf_n;
  logic [7:0] data;
  logic       ready;

  logic        oe_n, rd_n, m_valid;
  logic [7:0]  m_data;
  logic [31:0] empty_cnt, words;

  logic        oe_n4, rd_n4, m_valid4;
  logic [7:0]  m_data4;
  logic [3:0]  empty_cnt4, words4;

  int vecs = 0;
  int errs = 0;

  mst_rx_fifo_reader dut (
    .clk(clk), .rst(rst), .rxf_n_i(rxf_n), .data_i(data),
    .oe_n_o(oe_n), .rd_n_o(rd_n), .m_data_o(m_data),
    .m_valid_o(m_valid), .m_ready_i(ready),
    .empty_counter_o(empty_cnt), .words_o(words)
  );

  mst_rx_fifo_reader #(.DATA_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .rxf_n_i(rxf_n), .data_i(data),
    .oe_n_o(oe_n4), .rd_n_o(rd_n4), .m_data_o(m_data4),
    .m_valid_o(m_valid4), .m_ready_i(ready),
    .empty_counter_o(empty_cnt4), .words_o(words4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: bus phase, stream queue, counters
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX4  = 15;
  int         mph = 0;
  bit         moe = 1'b1;
  bit         mrd = 1'b1;
  logic [7:0] mq[$];
  longint     me = 0, mw = 0, me4 = 0, mw4 = 0;
  bit         mrs = 1'b0;

  bit         was_cap, was_pop;
  logic [7:0] popped;

  task automatic chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_edge(input bit r, input bit x, input bit y,
                            input logic [7:0] d);
    bit cap;
    bit pp;
    int occn;
    if (r) begin
      mph = 0; moe = 1; mrd = 1; mq.delete();
      me = 0; mw = 0; me4 = 0; mw4 = 0; mrs = 0;
      return;
    end
    cap  = !mrd && !x;
    pp   = (mq.size() > 0) && y;
    occn = mq.size() + int'(cap) - int'(pp);
    if (pp) void'(mq.pop_front());
    if (cap) mq.push_back(d);
    if (cap) begin
      mw  = sat_inc(mw, MAX32);
      mw4 = sat_inc(mw4, MAX4);
    end
    if (x) begin
      if (mrs) begin
        me = 1; me4 = 1;
      end else begin
        me  = sat_inc(me, MAX32);
        me4 = sat_inc(me4, MAX4);
      end
      mrs = 0;
    end else begin
      mrs = 1;
    end
    case (mph)
      0: begin
        moe = 1; mrd = 1;
        if (!x && occn <= 1) begin
          mph = 1; moe = 0;
        end
      end
      1: begin
        if (x) begin
          mph = 0; moe = 1; mrd = 1;
        end else begin
          mph = 2; moe = 0; mrd = !(occn <= 1);
        end
      end
      default: begin
        if (x) begin
          mph = 0; moe = 1; mrd = 1;
        end else begin
          moe = 0; mrd = !(occn <= 1);
        end
      end
    endcase
  endtask

  task automatic model_chk();
    chk("oe_n", oe_n, moe);
    chk("rd_n", rd_n, mrd);
    chk("m_valid", m_valid, mq.size() > 0);
    if (mq.size() > 0) chk("m_data", m_data, mq[0]);
    chk("empty_cnt", empty_cnt, me);
    chk("words", words, mw);
    chk("empty_cnt4", empty_cnt4, me4);
    chk("words4", words4, mw4);
  endtask

  task automatic step(input bit r, input bit x, input bit y,
                      input logic [7:0] d);
    rst = r; rxf_n = x; ready = y; data = d;
    #1;
    was_cap = !r && !rd_n && !x;
    was_pop = !r && m_valid && y;
    popped  = m_data;
    if (!r) chk("no_overflow", was_cap && mq.size() == 2, 0);
    model_edge(r, x, y, d);
    @(posedge clk);
    #1;
    model_chk();
  endtask

  typedef struct {
    bit         r, x, y;
    logic [7:0] d;
    bit         oe, rd, v;
    logic [7:0] md;
    int         e, w;
  } vec_t;

  vec_t tbl[20];

  logic [7:0] devq[$];
  logic [7:0] got[$];
  int         pop_cyc[$];

  task automatic run_dev(input int cycles, input int rdy_lo, input int rdy_hi);
    for (int c = 0; c < cycles; c++) begin
      bit y;
      y = !(c >= rdy_lo && c < rdy_hi);
      step(0, devq.size() == 0, y, devq.size() > 0 ? devq[0] : 8'h00);
      if (was_cap) void'(devq.pop_front());
      if (was_pop) begin
        got.push_back(popped);
        pop_cyc.push_back(c);
      end
    end
  endtask

  initial begin
    rst = 1; rxf_n = 1; ready = 1; data = 0;

    tbl[0]  = '{1,0,1,8'h00, 1,1,0,8'h00, 0,0};
    tbl[1]  = '{1,0,1,8'h00, 1,1,0,8'h00, 0,0};
    tbl[2]  = '{0,0,1,8'h00, 0,1,0,8'h00, 0,0};
    tbl[3]  = '{0,0,1,8'h00, 0,0,0,8'h00, 0,0};
    tbl[4]  = '{0,0,1,8'h10, 0,0,1,8'h10, 0,1};
    tbl[5]  = '{0,0,1,8'h11, 0,0,1,8'h11, 0,2};
    tbl[6]  = '{0,1,1,8'h12, 1,1,0,8'h00, 1,2};
    tbl[7]  = '{0,1,1,8'h00, 1,1,0,8'h00, 2,2};
    tbl[8]  = '{0,1,1,8'h00, 1,1,0,8'h00, 3,2};
    tbl[9]  = '{1,1,1,8'h00, 1,1,0,8'h00, 0,0};
    for (int i = 0; i < 5; i++)
      tbl[10+i] = '{0,1,1,8'h00, 1,1,0,8'h00, i+1,0};
    tbl[15] = '{0,0,1,8'h00, 0,1,0,8'h00, 5,0};
    tbl[16] = '{0,0,1,8'h00, 0,0,0,8'h00, 5,0};
    tbl[17] = '{0,0,1,8'h20, 0,0,1,8'h20, 5,1};
    tbl[18] = '{0,1,1,8'h00, 1,1,0,8'h00, 1,1};
    tbl[19] = '{0,1,1,8'h00, 1,1,0,8'h00, 2,1};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].x, tbl[i].y, tbl[i].d);
      chk($sformatf("t%0d.oe_n", i), oe_n, tbl[i].oe);
      chk($sformatf("t%0d.rd_n", i), rd_n, tbl[i].rd);
      chk($sformatf("t%0d.valid", i), m_valid, tbl[i].v);
      if (tbl[i].v || tbl[i].r)
        chk($sformatf("t%0d.data", i), m_data, tbl[i].md);
      chk($sformatf("t%0d.empty", i), empty_cnt, tbl[i].e);
      chk($sformatf("t%0d.words", i), words, tbl[i].w);
    end

    // 8-byte burst with the consumer always ready
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    devq.delete(); got.delete(); pop_cyc.delete();
    for (int i = 0; i < 8; i++) devq.push_back(8'h10 + 8'(i));
    run_dev(20, 0, 0);
    chk("burst.count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("burst.b%0d", i), got[i], 8'h10 + 8'(i));
    if (pop_cyc.size() == 8)
      chk("burst.rate", pop_cyc[7] - pop_cyc[0], 7);
    chk("burst.words", words, 8);

    // consumer stalls for 5 cycles mid-burst
    step(1, 1, 1, 0);
    devq.delete(); got.delete(); pop_cyc.delete();
    for (int i = 0; i < 12; i++) devq.push_back(8'h30 + 8'(i));
    begin
      bit stall_seen;
      stall_seen = 0;
      for (int c = 0; c < 30; c++) begin
        step(0, devq.size() == 0, !(c >= 4 && c < 9),
             devq.size() > 0 ? devq[0] : 8'h00);
        if (was_cap) void'(devq.pop_front());
        if (was_pop) got.push_back(popped);
        if (!oe_n && rd_n && mph == 2) stall_seen = 1;
      end
      chk("bp.stall_seen", stall_seen, 1);
    end
    chk("bp.count", got.size(), 12);
    for (int i = 0; i < 12 && i < got.size(); i++)
      chk($sformatf("bp.b%0d", i), got[i], 8'h30 + 8'(i));
    chk("bp.words", words, 12);

    // reset while READ holds two buffered bytes
    step(1, 1, 0, 0);
    for (int c = 0; c < 6; c++) step(0, 0, 0, 8'h50 + 8'(c));
    chk("mid.occ2_valid", m_valid, 1);
    chk("mid.stalled", rd_n, 1);
    step(1, 0, 0, 0);
    chk("mid.rst_oe", oe_n, 1);
    chk("mid.rst_rd", rd_n, 1);
    chk("mid.rst_valid", m_valid, 0);
    chk("mid.rst_words", words, 0);
    step(0, 0, 1, 8'h60);
    chk("mid.turn_oe", oe_n, 0);
    chk("mid.turn_rd", rd_n, 1);
    step(0, 0, 1, 8'h61);
    chk("mid.read_rd", rd_n, 0);
    step(0, 0, 1, 8'h62);
    chk("mid.first", m_data, 8'h62);

    // counter saturation on the 4-bit instance
    step(1, 1, 1, 0);
    for (int c = 0; c < 20; c++) step(0, 1, 1, 0);
    chk("sat.empty4", empty_cnt4, 15);
    chk("sat.empty32", empty_cnt, 20);
    devq.delete(); got.delete(); pop_cyc.delete();
    for (int i = 0; i < 20; i++) devq.push_back(8'(i));
    run_dev(40, 0, 0);
    chk("sat.words4", words4, 15);
    chk("sat.words32", words, 20);
    chk("sat.count", got.size(), 20);

    // randomized traffic against the model
    step(1, 1, 1, 0);
    begin
      bit x;
      x = 1;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(5) == 0) x = !x;
        step($urandom_range(299) == 0, x, $urandom_range(9) < 7,
             8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
